// File: rtl/watch_pkg.sv
// Shared types and constants for the BCD minutes:seconds stopwatch.
// Optional lap feature in watch_core is enabled by defining WATCH_LAP_EN.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int ONES_MAX = 9;
  localparam int TENS_MAX = 5;

endpackage

// File: rtl/bcd_cnt.sv
// One BCD digit: counts 0..MAX on en, wraps to 0 and flags wrap so the
// next digit up can be chained directly off it. clr has priority over en.
module bcd_cnt
  import watch_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output bcd_t q,
  output logic wrap
);

  localparam bcd_t MAX_V = bcd_t'(MAX);

  bcd_t q_q;
  bcd_t q_d;

  // Next digit value: clear, wrap at MAX, or increment.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q == MAX_V) ? '0 : bcd_t'(q_q + 4'd1);
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q    = q_q;
  assign wrap = en & ~clr & (q_q == MAX_V);

endmodule

// File: rtl/watch_core.sv
// Stopwatch core: edge-detects the divider output, prescales by
// TICKS_PER_SEC and advances a 00:00-59:59 BCD count under start/pause/clear.
// Define WATCH_LAP_EN to add the lap snapshot (btn_lap / lap_active).
//
// Handshake: btn_start, btn_clear (and btn_lap) are single-cycle pulses with
// no ready/backpressure; each is acted on at the clk edge that samples it.
// tick_in is a level, only its rising edge matters.
module watch_core
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef WATCH_LAP_EN
  input  logic       btn_lap,
  output logic       lap_active,
`endif
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_clear,
  output bcd_t       sec_ones,
  output bcd_t       sec_tens,
  output bcd_t       min_ones,
  output bcd_t       min_tens,
  output logic       running,
  output logic       carry_out,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_SEC - 1);

  state_e     state_q, state_d;
  logic       tick_q;
  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic       carry_q;

  logic tick_rise;
  logic count_ok;
  logic sec_step;
  logic w_so, w_st, w_mo, w_mt;
  bcd_t so, st, mo, mt;

  assign tick_rise = tick_in & ~tick_q;
  // A tick counts only if we were already running and no clear is arriving.
  assign count_ok  = tick_rise & (state_q == RUN) & ~btn_clear;
  assign sec_step  = count_ok & (pre_cnt_q == PRE_MAX);

  // Next-state logic: clear wins, start toggles between RUN and PAUSE.
  always_comb begin
    state_d = state_q;
    if (btn_clear) begin
      state_d = IDLE;
    end else if (btn_start) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler next value: zeroed by clear, advanced only by counting ticks.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (btn_clear) begin
      pre_cnt_d = '0;
    end else if (count_ok) begin
      pre_cnt_d = sec_step ? 8'd0 : pre_cnt_q + 8'd1;
    end
  end

  // Control registers; tick_q tracks tick_in in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tick_q    <= 1'b0;
      pre_cnt_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_in;
      pre_cnt_q <= pre_cnt_d;
      carry_q   <= w_mt;
    end
  end

  bcd_cnt #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .en(sec_step), .clr(btn_clear), .q(so), .wrap(w_so));
  bcd_cnt #(.MAX(TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .en(w_so), .clr(btn_clear), .q(st), .wrap(w_st));
  bcd_cnt #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .en(w_st), .clr(btn_clear), .q(mo), .wrap(w_mo));
  bcd_cnt #(.MAX(TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .en(w_mo), .clr(btn_clear), .q(mt), .wrap(w_mt));

  assign running   = (state_q == RUN);
  assign carry_out = carry_q;
  assign dbg_state = state_q;

`ifdef WATCH_LAP_EN
  logic lap_q, lap_d;
  bcd_t snap_so_q, snap_st_q, snap_mo_q, snap_mt_q;
  logic lap_take;

  // Snapshot is taken only on the edge that turns lap on, from pre-update digits.
  assign lap_take = btn_lap & ~btn_clear & (state_q != IDLE) & ~lap_q;

  // Lap toggle: clear forces off, lap in IDLE is ignored.
  always_comb begin
    lap_d = lap_q;
    if (btn_clear) begin
      lap_d = 1'b0;
    end else if (btn_lap && (state_q != IDLE)) begin
      lap_d = ~lap_q;
    end
  end

  // Lap flag and snapshot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q     <= 1'b0;
      snap_so_q <= '0;
      snap_st_q <= '0;
      snap_mo_q <= '0;
      snap_mt_q <= '0;
    end else begin
      lap_q <= lap_d;
      if (lap_take) begin
        snap_so_q <= so;
        snap_st_q <= st;
        snap_mo_q <= mo;
        snap_mt_q <= mt;
      end
    end
  end

  assign lap_active = lap_q;
  assign sec_ones   = lap_q ? snap_so_q : so;
  assign sec_tens   = lap_q ? snap_st_q : st;
  assign min_ones   = lap_q ? snap_mo_q : mo;
  assign min_tens   = lap_q ? snap_mt_q : mt;
`else
  assign sec_ones = so;
  assign sec_tens = st;
  assign min_ones = mo;
  assign min_tens = mt;
`endif

endmodule
